// File: rtl/sub_arbiter_seq_if.sv
// Bus between two requesters, the result consumer and the shared subtract engine.
// Handshake: a transfer happens on a rising edge where valid & ready are both high; ready never depends on data.
interface sub_arbiter_seq_if #(
  parameter int NUM_BYTES = 2
);
  localparam int W = 8 * NUM_BYTES;

  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [W-1:0] req_a0;
  logic [W-1:0] req_b0;
  logic [W-1:0] req_a1;
  logic [W-1:0] req_b1;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic         res_id;
  logic         res_ovf;
  logic         res_zero;

  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, res_ready,
    output req_ready, res_valid, res_data, res_id, res_ovf, res_zero
  );

  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, res_ready,
    input  req_ready, res_valid, res_data, res_id, res_ovf, res_zero
  );
endinterface

// File: rtl/sub_arbiter_seq.sv
// Round-robin shared signed subtractor: one 8-bit subtract-with-borrow slice,
// LSB byte first, result returned with overflow/zero flags.
module sub_arbiter_seq #(
  parameter int NUM_BYTES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  sub_arbiter_seq_if.slave     bus,
  output logic [1:0]           dbg_state_o
);
  localparam int W  = 8 * NUM_BYTES;
  localparam int CW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          a_sign_q, a_sign_d;
  logic          b_sign_q, b_sign_d;
  logic [W-1:0]  res_q, res_d;
  logic          id_q, id_d;
  logic          ovf_q, ovf_d;
  logic          zero_q, zero_d;

  logic          grant_id;
  logic [1:0]    ready;
  logic [W-1:0]  sel_a, sel_b;
  logic [8:0]    sum9;
  logic [W+7:0]  shifted;
  logic [W-1:0]  res_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      res_q    <= '0;
      id_q     <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      a_sign_q <= a_sign_d;
      b_sign_q <= b_sign_d;
      res_q    <= res_d;
      id_q     <= id_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  // Operands shift right one byte per cycle so the slice always reads bit 0;
  // result bytes enter from the top and land in place after NUM_BYTES shifts.
  always_comb begin
    grant_id = (bus.req_valid == 2'b11) ? ptr_q : bus.req_valid[1];
    ready    = 2'b00;
    if (state_q == IDLE && bus.req_valid[grant_id]) begin
      ready = grant_id ? 2'b10 : 2'b01;
    end
    sel_a    = grant_id ? bus.req_a1 : bus.req_a0;
    sel_b    = grant_id ? bus.req_b1 : bus.req_b0;
    sum9     = {1'b0, a_q[7:0]} + {1'b0, ~b_q[7:0]} + {8'b0, carry_q};
    shifted  = {sum9[7:0], res_q};
    res_next = shifted[W+7:8];
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    a_sign_d = a_sign_q;
    b_sign_d = b_sign_q;
    res_d    = res_q;
    id_d     = id_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    unique case (state_q)
      IDLE: begin
        if (|ready) begin
          a_d      = sel_a;
          b_d      = sel_b;
          a_sign_d = sel_a[W-1];
          b_sign_d = sel_b[W-1];
          id_d     = grant_id;
          cnt_d    = '0;
          carry_d  = 1'b1;
          state_d  = CALC;
        end
      end
      CALC: begin
        res_d   = res_next;
        carry_d = sum9[8];
        a_d     = a_q >> 8;
        b_d     = b_q >> 8;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          ovf_d   = (a_sign_q != b_sign_q) && (sum9[7] != a_sign_q);
          zero_d  = (res_next == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          ptr_d   = ~id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready = ready;
  assign bus.res_valid = (state_q == DONE);
  assign bus.res_data  = res_q;
  assign bus.res_id    = id_q;
  assign bus.res_ovf   = ovf_q;
  assign bus.res_zero  = zero_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_sub_arbiter_seq.sv
// Directed bench for sub_arbiter_seq: vector table plus alternation,
// backpressure and mid-operation reset sequences.
module tb_sub_arbiter_seq;
  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;
  int         checks;
  int         errors;

  sub_arbiter_seq_if #(.NUM_BYTES(2)) bus ();

  sub_arbiter_seq #(.NUM_BYTES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  typedef struct {
    logic        id;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t        vecs[8];
  logic [15:0] exp_q[$];
  logic        exp_id_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at a negedge; returns at a negedge where req_ready is nonzero.
  task automatic wait_ready(output logic ok);
    ok = 1'b0;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (|bus.req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
  endtask

  // Returns at a negedge with res_valid high; lat counts negedges waited.
  task automatic wait_result(output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (bus.res_valid) break;
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic ok;
    int   lat;
    bus.req_valid = v.id ? 2'b10 : 2'b01;
    if (v.id) begin
      bus.req_a1 = v.a;
      bus.req_b1 = v.b;
    end else begin
      bus.req_a0 = v.a;
      bus.req_b0 = v.b;
    end
    wait_ready(ok);
    check("ready_seen", {31'b0, ok}, 32'd1);
    check("ready_onehot", {30'b0, bus.req_ready}, v.id ? 32'd2 : 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    bus.req_a0 = 16'($urandom);
    bus.req_b0 = 16'($urandom);
    bus.req_a1 = 16'($urandom);
    bus.req_b1 = 16'($urandom);
    wait_result(lat);
    check("latency", lat, 32'd3);
    check("res_data", {16'b0, bus.res_data}, {16'b0, v.exp});
    check("res_id", {31'b0, bus.res_id}, {31'b0, v.id});
    check("res_ovf", {31'b0, bus.res_ovf}, {31'b0, v.ovf});
    check("res_zero", {31'b0, bus.res_zero}, {31'b0, v.zero});
    bus.res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("res_valid_drop", {31'b0, bus.res_valid}, 32'd0);
  endtask

  initial begin
    logic        ok;
    int          lat;
    logic [18:0] held;
    logic [15:0] e_data;
    logic        e_id;

    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.req_valid = 2'b00;
    bus.req_a0 = '0;
    bus.req_b0 = '0;
    bus.req_a1 = '0;
    bus.req_b1 = '0;
    bus.res_ready = 1'b0;

    vecs[0] = '{1'b0, 16'h1234, 16'h0235, 16'h0FFF, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'h0100, 16'h0001, 16'h00FF, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 16'h5A5A, 16'h5A5A, 16'h0000, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 16'h8000, 16'h7FFF, 16'h0001, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_state", {30'b0, dbg_state}, 32'd0);
    check("rst_req_ready", {30'b0, bus.req_ready}, 32'd0);
    check("rst_res_valid", {31'b0, bus.res_valid}, 32'd0);
    check("rst_res_flags", {13'b0, bus.res_id, bus.res_ovf, bus.res_zero, bus.res_data}, 32'd0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // both requesters always valid: grants alternate starting with 0
    do_reset();
    bus.req_a0 = 16'h0010;
    bus.req_b0 = 16'h0003;
    bus.req_a1 = 16'h0300;
    bus.req_b1 = 16'h0001;
    bus.req_valid = 2'b11;
    bus.res_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      wait_ready(ok);
      check("alt_ready_seen", {31'b0, ok}, 32'd1);
      check("alt_grant", {30'b0, bus.req_ready}, (g % 2 == 1) ? 32'd2 : 32'd1);
      exp_id_q.push_back(g % 2 == 1);
      exp_q.push_back((g % 2 == 1) ? 16'h02FF : 16'h000D);
      @(posedge clk);
      wait_result(lat);
      e_id   = exp_id_q.pop_front();
      e_data = exp_q.pop_front();
      check("alt_res_id", {31'b0, bus.res_id}, {31'b0, e_id});
      check("alt_res_data", {16'b0, bus.res_data}, {16'b0, e_data});
      @(posedge clk);
      @(negedge clk);
    end

    // backpressure in DONE
    bus.res_ready = 1'b0;
    wait_ready(ok);
    check("bp_grant", {30'b0, bus.req_ready}, 32'd1);
    @(posedge clk);
    wait_result(lat);
    check("bp_valid", {31'b0, bus.res_valid}, 32'd1);
    held = {bus.res_id, bus.res_ovf, bus.res_zero, bus.res_data};
    check("bp_first", {13'b0, held}, {13'b0, 3'b000, 16'h000D});
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_hold_valid", {31'b0, bus.res_valid}, 32'd1);
      check("bp_hold_out", {13'b0, bus.res_id, bus.res_ovf, bus.res_zero, bus.res_data}, {13'b0, held});
      check("bp_hold_ready", {30'b0, bus.req_ready}, 32'd0);
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("bp_release_valid", {31'b0, bus.res_valid}, 32'd0);
    check("bp_next_grant", {30'b0, bus.req_ready}, 32'd2);
    bus.req_valid = 2'b00;
    bus.res_ready = 1'b0;

    // reset in the middle of CALC, pointer left favouring requester 1
    bus.req_a0 = 16'h1234;
    bus.req_b0 = 16'h0235;
    bus.req_valid = 2'b01;
    wait_ready(ok);
    check("mid_ready_seen", {31'b0, ok}, 32'd1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("mid_in_calc", {30'b0, dbg_state}, 32'd1);
    reset = 1'b1;
    bus.req_valid = 2'b00;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_state", {30'b0, dbg_state}, 32'd0);
    check("mid_rst_valid", {31'b0, bus.res_valid}, 32'd0);
    check("mid_rst_out", {13'b0, bus.res_id, bus.res_ovf, bus.res_zero, bus.res_data}, 32'd0);
    reset = 1'b0;
    bus.req_a1 = 16'h0300;
    bus.req_b1 = 16'h0001;
    bus.req_valid = 2'b11;
    #1;
    check("mid_post_grant", {30'b0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    wait_result(lat);
    check("mid_post_latency", lat, 32'd3);
    check("mid_post_data", {16'b0, bus.res_data}, 32'h0000_0FFF);
    bus.res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.res_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
